dfi_modport: RTL and testbench
==============================

Name: dfi_modport

Overview:
- PHY-side DFI control-plane responder. Faces the memory controller (MC) on the DFI update, PHY-master, low-power and init/status handshakes.
- Generates every PHY-owned handshake signal so the DFI protocol rules hold: defined values, ack/req pairing, response windows and mutually exclusive states.
- Sits between the DFI bus and the PHY's internal calibration/power sequencer, which triggers requests through local ports.

Parameters:
- TLP_RESP, 8, max cycles from lp_*_req to lp_*_ack before MC may withdraw; internal ack latency must be smaller.
- LP_ACK_DLY, 2, cycles of stable lp_*_req before lp_*_ack asserts (1..TLP_RESP-1).
- TPHYUPD_RESP, 16, max cycles from phyupd_req to phyupd_ack; exceeding sets an error.
- UPD_CYCLES, 4, cycles phyupd_req/phymstr_req is held after the ack is seen.
- INIT_CYCLES, 10, cycles from init_start rise to init_complete.

Ports:
- clock in 1: DFI clock, all logic on posedge.
- reset in 1: asynchronous, active-low reset.
- ctrlupd_req in 1: MC update request.
- ctrlupd_ack out 1: PHY ack to ctrlupd_req.
- phyupd_req out 1: PHY update request.
- phyupd_type out 2: update type, held with phyupd_req.
- phyupd_ack in 1: MC ack.
- phymstr_req out 1: PHY-master request.
- phymstr_type out 2, phymstr_cs_state out 2, phymstr_state_sel out 1: held with phymstr_req.
- phymstr_ack in 1: MC ack.
- lp_ctrl_req in 1, lp_ctrl_wakeup in 6, lp_ctrl_ack out 1: control low-power handshake.
- lp_data_req in 1, lp_data_wakeup in 6, lp_data_ack out 1: data low-power handshake.
- init_start in 1, init_complete out 1: init/frequency-change handshake.
- freq_fsp in 2, freq_ratio in 2, frequency in 5: status inputs, sampled at init_start rise.
- upd_trig in 1, upd_trig_type in 2: internal phyupd trigger (1-cycle pulse).
- mstr_trig in 1, mstr_trig_type in 2, mstr_trig_cs in 2, mstr_trig_sel in 1: internal phymstr trigger.
- lp_ctrl_wakeup_q out 6, lp_data_wakeup_q out 6: wakeup value latched at ack.
- cur_fsp out 2, cur_ratio out 2, cur_freq out 5: latched status.
- err_phyupd_timeout out 1: sticky timeout flag.

Behaviour:
- Reset: all outputs 0. Every output is 2-state at all times (no X/Z).
- ctrlupd: ack_q is set 1 cycle after ctrlupd_req is sampled high, only if no phyupd/phymstr handshake is active. ctrlupd_ack = ack_q & ctrlupd_req (combinational), so ack is never high without req. ack_q clears when req is low.
- phyupd FSM: IDLE -> REQ -> HOLD -> IDLE.
  - IDLE->REQ on upd_trig when init_start=0, ctrlupd_req=0, no phymstr active. Latch the type. phyupd_req=1.
  - REQ: wait for phyupd_ack. A wait counter reaching TPHYUPD_RESP sets err_phyupd_timeout; req stays high.
  - On ack: HOLD for UPD_CYCLES cycles, then drop req and go to IDLE.
  - A new request is not allowed until phyupd_ack has been seen low for at least 1 cycle.
- phymstr FSM: same structure; no timeout.
  - phyupd and phymstr are never requested together. If both triggers arrive in the same cycle, phyupd wins and the phymstr trigger is pended.
  - Triggers arriving while busy are pended (1 deep each).
  - Triggers while init_start=1 are pended until init_start falls.
- lp_ctrl / lp_data (independent, identical logic):
  - Count cycles of req=1 & ack=0. When the count reaches LP_ACK_DLY, assert ack and latch the wakeup value.
  - ack holds while req=1 and deasserts the cycle after req is sampled low. If req falls before ack, the count clears.
  - lp_*_req while init_start=1 is ignored.
- init:
  - On init_start rise: init_complete->0, latch freq_fsp/freq_ratio/frequency into cur_*, start counting.
  - After INIT_CYCLES cycles with init_start still 1: init_complete->1.
  - If init_start falls early, abort: init_complete->1 and the latched values are kept.
  - init_complete reset value is 0; it is first set by the first init sequence.
- Async reset mid-handshake returns all FSMs to IDLE and clears the pending triggers and the error flag.

Test Plan:
- lp_ctrl_req=1, wakeup=6'h0A at cycle 0 -> lp_ctrl_ack=1 at cycle 2, lp_ctrl_wakeup_q=0x0A. Drop req -> ack=0 the next cycle.
- ctrlupd_req pulse high for 3 cycles -> ctrlupd_ack high cycles 2-3 only. ack=0 the same cycle req falls.
- upd_trig with type=2'b01, MC acks after 3 cycles -> phyupd_req held until ack+4 cycles, phyupd_type=01, no error. Repeat with no ack for 17 cycles -> err_phyupd_timeout=1.
- upd_trig and mstr_trig in the same cycle -> phyupd_req first. phymstr_req rises only after phyupd completes and phyupd_ack=0. They are never high together.
- init_start rises with frequency=5'd7 -> init_complete=0, after 10 cycles init_complete=1, cur_freq=7. upd_trig during init -> phyupd_req only after init_start falls.
- reset asserted during phyupd REQ -> phyupd_req=0 immediately and the FSM returns to IDLE.

Source files
------------

// File: rtl/dfi_modport.sv
// PHY-side DFI control-plane responder: update, PHY-master, low-power
// and init handshakes toward the memory controller.
module dfi_lp_resp #(
   parameter int DLY = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_i,
   input  logic [5:0] wakeup_i,
   input  logic       block_i,
   output logic       ack_o,
   output logic [5:0] wakeup_o
);
   localparam int CW = $clog2(DLY + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          ack_q, ack_d;
   logic [5:0]    wk_q, wk_d;

   always_comb begin
      cnt_d = cnt_q;
      ack_d = ack_q;
      wk_d  = wk_q;
      if (!req_i) begin
         cnt_d = '0;
         ack_d = 1'b0;
      end else if (!ack_q) begin
         if (block_i) begin
            cnt_d = '0;
         end else if (cnt_q == CW'(DLY - 1)) begin
            ack_d = 1'b1;
            wk_d  = wakeup_i;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         ack_q <= 1'b0;
         wk_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         ack_q <= ack_d;
         wk_q  <= wk_d;
      end
   end

   assign ack_o    = ack_q;
   assign wakeup_o = wk_q;
endmodule

module dfi_modport #(
   parameter int TLP_RESP     = 8,
   parameter int LP_ACK_DLY   = 2,
   parameter int TPHYUPD_RESP = 16,
   parameter int UPD_CYCLES   = 4,
   parameter int INIT_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ctrlupd_req,
   output logic       ctrlupd_ack,
   output logic       phyupd_req,
   output logic [1:0] phyupd_type,
   input  logic       phyupd_ack,
   output logic       phymstr_req,
   output logic [1:0] phymstr_type,
   output logic [1:0] phymstr_cs_state,
   output logic       phymstr_state_sel,
   input  logic       phymstr_ack,
   input  logic       lp_ctrl_req,
   input  logic [5:0] lp_ctrl_wakeup,
   output logic       lp_ctrl_ack,
   input  logic       lp_data_req,
   input  logic [5:0] lp_data_wakeup,
   output logic       lp_data_ack,
   input  logic       init_start,
   output logic       init_complete,
   input  logic [1:0] freq_fsp,
   input  logic [1:0] freq_ratio,
   input  logic [4:0] frequency,
   input  logic       upd_trig,
   input  logic [1:0] upd_trig_type,
   input  logic       mstr_trig,
   input  logic [1:0] mstr_trig_type,
   input  logic [1:0] mstr_trig_cs,
   input  logic       mstr_trig_sel,
   output logic [5:0] lp_ctrl_wakeup_q,
   output logic [5:0] lp_data_wakeup_q,
   output logic [1:0] cur_fsp,
   output logic [1:0] cur_ratio,
   output logic [4:0] cur_freq,
   output logic       err_phyupd_timeout
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} hs_e;

   // Ack latency is clamped inside the MC response window.
   localparam int LP_DLY0 = (LP_ACK_DLY < TLP_RESP) ? LP_ACK_DLY : TLP_RESP - 1;
   localparam int LP_DLY  = (LP_DLY0 < 1) ? 1 : LP_DLY0;
   localparam int UCMAX = (TPHYUPD_RESP > UPD_CYCLES) ? TPHYUPD_RESP : UPD_CYCLES;
   localparam int UCW   = $clog2(UCMAX + 1);
   localparam int MCW   = $clog2(UPD_CYCLES + 1);
   localparam int IW    = $clog2(INIT_CYCLES + 1);

   hs_e           upd_st_q, upd_st_d;
   logic [UCW-1:0] upd_cnt_q, upd_cnt_d;
   logic [1:0]    upd_type_q, upd_type_d;
   logic [1:0]    upd_ptype_q, upd_ptype_d;
   logic          upd_pend_q, upd_pend_d;
   logic          err_q, err_d;

   hs_e           mstr_st_q, mstr_st_d;
   logic [MCW-1:0] mstr_cnt_q, mstr_cnt_d;
   logic [4:0]    mstr_info_q, mstr_info_d;
   logic [4:0]    mstr_pinfo_q, mstr_pinfo_d;
   logic          mstr_pend_q, mstr_pend_d;

   logic          cu_ack_q, cu_ack_d;

   logic          init_prev_q, init_prev_d;
   logic          init_act_q, init_act_d;
   logic [IW-1:0] init_cnt_q, init_cnt_d;
   logic          init_done_q, init_done_d;
   logic [8:0]    cur_q, cur_d;

   logic       upd_busy, upd_want, upd_go;
   logic       mstr_busy, mstr_want, mstr_go;
   logic [4:0] mstr_tinfo;

   assign upd_busy   = (upd_st_q != S_IDLE);
   assign mstr_busy  = (mstr_st_q != S_IDLE);
   assign upd_want   = upd_trig | upd_pend_q;
   assign mstr_want  = mstr_trig | mstr_pend_q;
   assign mstr_tinfo = {mstr_trig_type, mstr_trig_cs, mstr_trig_sel};

   assign upd_go = !upd_busy && upd_want && !init_start &&
                   !ctrlupd_req && !mstr_busy && !phyupd_ack;
   // phyupd keeps priority: phymstr waits while any phyupd is wanted.
   assign mstr_go = !mstr_busy && mstr_want && !init_start &&
                    !ctrlupd_req && !upd_busy && !upd_want &&
                    !phyupd_ack && !phymstr_ack;

   always_comb begin
      upd_st_d    = upd_st_q;
      upd_cnt_d   = upd_cnt_q;
      upd_type_d  = upd_type_q;
      upd_ptype_d = upd_ptype_q;
      upd_pend_d  = upd_pend_q;
      err_d       = err_q;
      if (upd_trig) upd_ptype_d = upd_trig_type;
      if (upd_go) begin
         upd_pend_d = 1'b0;
         upd_type_d = upd_trig ? upd_trig_type : upd_ptype_q;
         upd_st_d   = S_REQ;
         upd_cnt_d  = '0;
      end else if (upd_trig) begin
         upd_pend_d = 1'b1;
      end
      unique case (upd_st_q)
         S_REQ: begin
            if (phyupd_ack) begin
               upd_st_d  = S_HOLD;
               upd_cnt_d = '0;
            end else begin
               if (upd_cnt_q != UCW'(TPHYUPD_RESP))
                  upd_cnt_d = upd_cnt_q + 1'b1;
               if (upd_cnt_q == UCW'(TPHYUPD_RESP - 1))
                  err_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (upd_cnt_q == UCW'(UPD_CYCLES - 1))
               upd_st_d = S_IDLE;
            else
               upd_cnt_d = upd_cnt_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      mstr_st_d    = mstr_st_q;
      mstr_cnt_d   = mstr_cnt_q;
      mstr_info_d  = mstr_info_q;
      mstr_pinfo_d = mstr_pinfo_q;
      mstr_pend_d  = mstr_pend_q;
      if (mstr_trig) mstr_pinfo_d = mstr_tinfo;
      if (mstr_go) begin
         mstr_pend_d = 1'b0;
         mstr_info_d = mstr_trig ? mstr_tinfo : mstr_pinfo_q;
         mstr_st_d   = S_REQ;
         mstr_cnt_d  = '0;
      end else if (mstr_trig) begin
         mstr_pend_d = 1'b1;
      end
      unique case (mstr_st_q)
         S_REQ: begin
            if (phymstr_ack) begin
               mstr_st_d  = S_HOLD;
               mstr_cnt_d = '0;
            end
         end
         S_HOLD: begin
            if (mstr_cnt_q == MCW'(UPD_CYCLES - 1))
               mstr_st_d = S_IDLE;
            else
               mstr_cnt_d = mstr_cnt_q + 1'b1;
         end
         default: ;
      endcase
   end

   assign cu_ack_d = ctrlupd_req & (cu_ack_q | !(upd_busy | mstr_busy));

   always_comb begin
      init_prev_d = init_start;
      init_act_d  = init_act_q;
      init_cnt_d  = init_cnt_q;
      init_done_d = init_done_q;
      cur_d       = cur_q;
      if (init_start && !init_prev_q) begin
         init_done_d = 1'b0;
         init_act_d  = 1'b1;
         init_cnt_d  = IW'(1);
         cur_d       = {freq_fsp, freq_ratio, frequency};
      end else if (init_act_q) begin
         // An early fall of init_start aborts but still completes.
         if (!init_start || init_cnt_q == IW'(INIT_CYCLES - 1)) begin
            init_done_d = 1'b1;
            init_act_d  = 1'b0;
         end else begin
            init_cnt_d = init_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_st_q     <= S_IDLE;
         upd_cnt_q    <= '0;
         upd_type_q   <= '0;
         upd_ptype_q  <= '0;
         upd_pend_q   <= 1'b0;
         err_q        <= 1'b0;
         mstr_st_q    <= S_IDLE;
         mstr_cnt_q   <= '0;
         mstr_info_q  <= '0;
         mstr_pinfo_q <= '0;
         mstr_pend_q  <= 1'b0;
         cu_ack_q     <= 1'b0;
         init_prev_q  <= 1'b0;
         init_act_q   <= 1'b0;
         init_cnt_q   <= '0;
         init_done_q  <= 1'b0;
         cur_q        <= '0;
      end else begin
         upd_st_q     <= upd_st_d;
         upd_cnt_q    <= upd_cnt_d;
         upd_type_q   <= upd_type_d;
         upd_ptype_q  <= upd_ptype_d;
         upd_pend_q   <= upd_pend_d;
         err_q        <= err_d;
         mstr_st_q    <= mstr_st_d;
         mstr_cnt_q   <= mstr_cnt_d;
         mstr_info_q  <= mstr_info_d;
         mstr_pinfo_q <= mstr_pinfo_d;
         mstr_pend_q  <= mstr_pend_d;
         cu_ack_q     <= cu_ack_d;
         init_prev_q  <= init_prev_d;
         init_act_q   <= init_act_d;
         init_cnt_q   <= init_cnt_d;
         init_done_q  <= init_done_d;
         cur_q        <= cur_d;
      end
   end

   dfi_lp_resp #(.DLY(LP_DLY)) u_lp_ctrl (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (lp_ctrl_req),
      .wakeup_i (lp_ctrl_wakeup),
      .block_i  (init_start),
      .ack_o    (lp_ctrl_ack),
      .wakeup_o (lp_ctrl_wakeup_q)
   );

   dfi_lp_resp #(.DLY(LP_DLY)) u_lp_data (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (lp_data_req),
      .wakeup_i (lp_data_wakeup),
      .block_i  (init_start),
      .ack_o    (lp_data_ack),
      .wakeup_o (lp_data_wakeup_q)
   );

   assign ctrlupd_ack = cu_ack_q & ctrlupd_req;
   assign phyupd_req  = upd_busy;
   assign phyupd_type = upd_busy ? upd_type_q : 2'b00;
   assign phymstr_req = mstr_busy;
   assign {phymstr_type, phymstr_cs_state, phymstr_state_sel} =
          mstr_busy ? mstr_info_q : 5'd0;
   assign init_complete = init_done_q;
   assign {cur_fsp, cur_ratio, cur_freq} = cur_q;
   assign err_phyupd_timeout = err_q;
endmodule

// File: tb/tb_dfi_modport.sv
// Bench for dfi_modport: directed handshake scenarios, then random
// traffic against a behavioural low-power and MC model.
module tb_dfi_modport;
   localparam int LP_DLY = 2;
   localparam int HOLD   = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ctrlupd_req, ctrlupd_ack;
   logic       phyupd_req, phyupd_ack;
   logic [1:0] phyupd_type;
   logic       phymstr_req, phymstr_ack, phymstr_state_sel;
   logic [1:0] phymstr_type, phymstr_cs_state;
   logic       lp_ctrl_req, lp_ctrl_ack, lp_data_req, lp_data_ack;
   logic [5:0] lp_ctrl_wakeup, lp_data_wakeup;
   logic [5:0] lp_ctrl_wakeup_q, lp_data_wakeup_q;
   logic       init_start, init_complete;
   logic [1:0] freq_fsp, freq_ratio, cur_fsp, cur_ratio;
   logic [4:0] frequency, cur_freq;
   logic       upd_trig, mstr_trig, mstr_trig_sel;
   logic [1:0] upd_trig_type, mstr_trig_type, mstr_trig_cs;
   logic       err_phyupd_timeout;

   int n_vec = 0;
   int n_bad = 0;

   int  upd_lat, mstr_lat;
   bit  upd_acked, mstr_acked;
   bit  lp_ack_m [2];
   logic [5:0] lp_wq_m [2];
   int  lp_run [2];

   dfi_modport dut (
      .clk(clk), .rst_n(rst_n),
      .ctrlupd_req(ctrlupd_req), .ctrlupd_ack(ctrlupd_ack),
      .phyupd_req(phyupd_req), .phyupd_type(phyupd_type),
      .phyupd_ack(phyupd_ack),
      .phymstr_req(phymstr_req), .phymstr_type(phymstr_type),
      .phymstr_cs_state(phymstr_cs_state),
      .phymstr_state_sel(phymstr_state_sel),
      .phymstr_ack(phymstr_ack),
      .lp_ctrl_req(lp_ctrl_req), .lp_ctrl_wakeup(lp_ctrl_wakeup),
      .lp_ctrl_ack(lp_ctrl_ack),
      .lp_data_req(lp_data_req), .lp_data_wakeup(lp_data_wakeup),
      .lp_data_ack(lp_data_ack),
      .init_start(init_start), .init_complete(init_complete),
      .freq_fsp(freq_fsp), .freq_ratio(freq_ratio), .frequency(frequency),
      .upd_trig(upd_trig), .upd_trig_type(upd_trig_type),
      .mstr_trig(mstr_trig), .mstr_trig_type(mstr_trig_type),
      .mstr_trig_cs(mstr_trig_cs), .mstr_trig_sel(mstr_trig_sel),
      .lp_ctrl_wakeup_q(lp_ctrl_wakeup_q),
      .lp_data_wakeup_q(lp_data_wakeup_q),
      .cur_fsp(cur_fsp), .cur_ratio(cur_ratio), .cur_freq(cur_freq),
      .err_phyupd_timeout(err_phyupd_timeout)
   );

   always #5 clk = ~clk;

   task automatic expect_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic clr_in();
      ctrlupd_req = 0; phyupd_ack = 0; phymstr_ack = 0;
      lp_ctrl_req = 0; lp_ctrl_wakeup = 0;
      lp_data_req = 0; lp_data_wakeup = 0;
      init_start = 0; freq_fsp = 0; freq_ratio = 0; frequency = 0;
      upd_trig = 0; upd_trig_type = 0;
      mstr_trig = 0; mstr_trig_type = 0; mstr_trig_cs = 0;
      mstr_trig_sel = 0;
   endtask

   // MC side: ack each request once, after a random delay.
   task automatic mc_cycle();
      phyupd_ack = 0;
      phymstr_ack = 0;
      if (!phyupd_req) upd_acked = 0;
      else if (!upd_acked) begin
         if (upd_lat == 0) begin
            phyupd_ack = 1; upd_acked = 1;
            upd_lat = $urandom_range(0, 4);
         end else upd_lat--;
      end
      if (!phymstr_req) mstr_acked = 0;
      else if (!mstr_acked) begin
         if (mstr_lat == 0) begin
            phymstr_ack = 1; mstr_acked = 1;
            mstr_lat = $urandom_range(0, 4);
         end else mstr_lat--;
      end
      cyc();
   endtask

   // Low-power rule: ack after LP_DLY consecutive sampled requests
   // outside init, held while req stays high.
   task automatic lp_model(input int c, input bit req, input bit init,
                           input logic [5:0] wk);
      if (!req) begin
         lp_run[c] = 0;
         lp_ack_m[c] = 0;
      end else if (!lp_ack_m[c]) begin
         if (init) lp_run[c] = 0;
         else begin
            lp_run[c]++;
            if (lp_run[c] == LP_DLY) begin
               lp_ack_m[c] = 1;
               lp_wq_m[c] = wk;
               lp_run[c] = 0;
            end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit m_seen;
      int both;
      clr_in();
      upd_lat = 1; mstr_lat = 1; upd_acked = 0; mstr_acked = 0;
      rst_n = 0;
      repeat (3) cyc();
      expect_eq("rst_outs",
         {ctrlupd_ack, phyupd_req, phyupd_type, phymstr_req, phymstr_type,
          phymstr_cs_state, phymstr_state_sel, lp_ctrl_ack, lp_data_ack,
          lp_ctrl_wakeup_q, lp_data_wakeup_q, init_complete, cur_fsp,
          cur_ratio, cur_freq, err_phyupd_timeout}, 64'd0);
      rst_n = 1;
      cyc();
      expect_eq("rst_rel_init", init_complete, 0);

      lp_ctrl_req = 1; lp_ctrl_wakeup = 6'h0A;
      cyc(); expect_eq("lp_ack_c1", lp_ctrl_ack, 0);
      cyc(); expect_eq("lp_ack_c2", lp_ctrl_ack, 1);
      expect_eq("lp_wq", lp_ctrl_wakeup_q, 6'h0A);
      lp_ctrl_wakeup = 6'h15;
      cyc(); expect_eq("lp_ack_hold", lp_ctrl_ack, 1);
      expect_eq("lp_wq_hold", lp_ctrl_wakeup_q, 6'h0A);
      lp_ctrl_req = 0;
      cyc(); expect_eq("lp_ack_drop", lp_ctrl_ack, 0);
      lp_data_req = 1; lp_data_wakeup = 6'h2C;
      cyc(); lp_data_req = 0;
      cyc(); expect_eq("lpd_abort", lp_data_ack, 0);
      lp_data_req = 1;
      cyc(); expect_eq("lpd_c1", lp_data_ack, 0);
      cyc(); expect_eq("lpd_c2", lp_data_ack, 1);
      expect_eq("lpd_wq", lp_data_wakeup_q, 6'h2C);
      lp_data_req = 0;
      cyc();

      ctrlupd_req = 1;
      #1 expect_eq("cu_same", ctrlupd_ack, 0);
      cyc(); expect_eq("cu_c1", ctrlupd_ack, 1);
      cyc(); expect_eq("cu_c2", ctrlupd_ack, 1);
      ctrlupd_req = 0;
      #1 expect_eq("cu_fall", ctrlupd_ack, 0);
      cyc(); expect_eq("cu_after", ctrlupd_ack, 0);

      upd_trig = 1; upd_trig_type = 2'b01;
      cyc(); upd_trig = 0;
      expect_eq("upd_req", phyupd_req, 1);
      expect_eq("upd_type", phyupd_type, 2'b01);
      cyc(); cyc();
      phyupd_ack = 1;
      cyc(); phyupd_ack = 0;
      for (int i = 0; i < HOLD; i++) begin
         expect_eq("upd_hold", phyupd_req, 1);
         cyc();
      end
      expect_eq("upd_drop", phyupd_req, 0);
      expect_eq("upd_noerr", err_phyupd_timeout, 0);

      phyupd_ack = 1; upd_trig = 1; upd_trig_type = 2'b11;
      cyc(); upd_trig = 0;
      expect_eq("upd_ackhi", phyupd_req, 0);
      phyupd_ack = 0;
      cyc(); expect_eq("upd_pended", phyupd_req, 1);
      expect_eq("upd_ptype", phyupd_type, 2'b11);
      phyupd_ack = 1;
      cyc(); phyupd_ack = 0;
      repeat (HOLD) cyc();
      expect_eq("upd_pdone", phyupd_req, 0);

      upd_trig = 1; upd_trig_type = 2'b10;
      cyc(); upd_trig = 0;
      repeat (15) cyc();
      expect_eq("tmo_early", err_phyupd_timeout, 0);
      cyc();
      expect_eq("tmo_set", err_phyupd_timeout, 1);
      expect_eq("tmo_req", phyupd_req, 1);
      #1 rst_n = 0;
      #1 expect_eq("rst_req", phyupd_req, 0);
      expect_eq("rst_err", err_phyupd_timeout, 0);
      cyc(); rst_n = 1;
      cyc(); expect_eq("rst_idle", phyupd_req, 0);

      upd_lat = 1; mstr_lat = 1;
      upd_trig = 1; upd_trig_type = 2'b11;
      mstr_trig = 1; mstr_trig_type = 2'b10;
      mstr_trig_cs = 2'b01; mstr_trig_sel = 1;
      cyc(); upd_trig = 0; mstr_trig = 0;
      expect_eq("both_upd", phyupd_req, 1);
      expect_eq("both_mstr", phymstr_req, 0);
      m_seen = 0; both = 0;
      for (int i = 0; i < 60 && !m_seen; i++) begin
         mc_cycle();
         if (phyupd_req && phymstr_req) both++;
         if (phymstr_req) begin
            m_seen = 1;
            expect_eq("mstr_after", phyupd_req, 0);
            expect_eq("mstr_info",
               {phymstr_type, phymstr_cs_state, phymstr_state_sel},
               5'b10_01_1);
         end
      end
      expect_eq("mstr_rose", m_seen, 1);
      for (int i = 0; i < 30 && phymstr_req; i++) mc_cycle();
      expect_eq("mstr_done", phymstr_req, 0);
      expect_eq("never_both", both, 0);
      phyupd_ack = 0; phymstr_ack = 0;

      freq_fsp = 2'd2; freq_ratio = 2'd1; frequency = 5'd7;
      init_start = 1;
      cyc();
      upd_trig = 1; upd_trig_type = 2'b01; frequency = 5'd3;
      lp_ctrl_req = 1;
      cyc(); upd_trig = 0;
      expect_eq("init_busy", init_complete, 0);
      expect_eq("init_freq", cur_freq, 5'd7);
      expect_eq("init_fsp", {cur_fsp, cur_ratio}, 4'b10_01);
      repeat (7) cyc();
      expect_eq("init_c9", init_complete, 0);
      expect_eq("init_noupd", phyupd_req, 0);
      expect_eq("init_nolp", lp_ctrl_ack, 0);
      cyc();
      expect_eq("init_c10", init_complete, 1);
      expect_eq("init_freq2", cur_freq, 5'd7);
      init_start = 0; lp_ctrl_req = 0;
      cyc(); expect_eq("upd_post_init", phyupd_req, 1);
      phyupd_ack = 1;
      cyc(); phyupd_ack = 0;
      repeat (HOLD) cyc();
      expect_eq("upd_post_done", phyupd_req, 0);

      freq_fsp = 2'd1; freq_ratio = 2'd2; frequency = 5'd20;
      init_start = 1;
      cyc(); expect_eq("abort_busy", init_complete, 0);
      expect_eq("abort_freq", cur_freq, 5'd20);
      cyc(); cyc();
      init_start = 0;
      cyc(); expect_eq("abort_done", init_complete, 1);
      expect_eq("abort_keep", {cur_fsp, cur_ratio}, 4'b01_10);

      clr_in();
      rst_n = 0; cyc(); rst_n = 1; cyc();
      upd_acked = 0; mstr_acked = 0; upd_lat = 2; mstr_lat = 2;
      for (int c = 0; c < 2; c++) begin
         lp_ack_m[c] = 0; lp_wq_m[c] = 0; lp_run[c] = 0;
      end
      for (int t = 0; t < 600; t++) begin
         if ($urandom_range(0, 5) == 0) lp_ctrl_req = ~lp_ctrl_req;
         if ($urandom_range(0, 5) == 0) lp_data_req = ~lp_data_req;
         lp_ctrl_wakeup = 6'($urandom);
         lp_data_wakeup = 6'($urandom);
         if ($urandom_range(0, 39) == 0) init_start = ~init_start;
         if ($urandom_range(0, 9) == 0) ctrlupd_req = ~ctrlupd_req;
         upd_trig = ($urandom_range(0, 9) == 0);
         upd_trig_type = 2'($urandom);
         mstr_trig = ($urandom_range(0, 9) == 0);
         {mstr_trig_type, mstr_trig_cs, mstr_trig_sel} = 5'($urandom);
         lp_model(0, lp_ctrl_req, init_start, lp_ctrl_wakeup);
         lp_model(1, lp_data_req, init_start, lp_data_wakeup);
         mc_cycle();
         expect_eq("rnd_lpc_ack", lp_ctrl_ack, lp_ack_m[0]);
         expect_eq("rnd_lpc_wq", lp_ctrl_wakeup_q, lp_wq_m[0]);
         expect_eq("rnd_lpd_ack", lp_data_ack, lp_ack_m[1]);
         expect_eq("rnd_lpd_wq", lp_data_wakeup_q, lp_wq_m[1]);
         expect_eq("rnd_excl", phyupd_req & phymstr_req, 0);
         expect_eq("rnd_cu", ctrlupd_ack & ~ctrlupd_req, 0);
         expect_eq("rnd_err", err_phyupd_timeout, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
